// File: rtl/pulse_gen.sv
// Delayed fixed-width pulse generator: qualifying trigger edges are timestamped into a
// due-time FIFO and replayed as pulses; drops from overflow or overlap are counted.
module pulse_gen #(
   parameter int QUEUE_LOG2 = 4,
   parameter int TS_WIDTH   = 32
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  trig_i,
   input  logic [1:0]            TRIG_EDGE,
   input  logic [TS_WIDTH-1:0]   DELAY,
   input  logic [TS_WIDTH-1:0]   WIDTH,
   input  logic                  FORCE_RST,
   output logic                  out_o,
   output logic                  perr_o,
   output logic [QUEUE_LOG2:0]   QUEUED,
   output logic [TS_WIDTH-1:0]   DROPPED
);

   localparam int DEPTH = 1 << QUEUE_LOG2;

   logic [TS_WIDTH-1:0]   ts;
   logic                  trig_prev;
   logic [TS_WIDTH-1:0]   wcnt;
   logic [TS_WIDTH-1:0]   due_q [DEPTH];
   logic [QUEUE_LOG2-1:0] wr_ptr, rd_ptr;

   logic                  rise, fall, edge_hit, live;
   logic                  q_empty, q_full, pop, overlap, push_ok, ovf_drop;
   logic [TS_WIDTH-1:0]   due_in, width_eff, drop_next;
   logic [1:0]            n_drop;
   logic [TS_WIDTH:0]     drop_sum;

   assign rise = trig_i & ~trig_prev;
   assign fall = ~trig_i & trig_prev;

   always_comb begin
      edge_hit = rise;
      case (TRIG_EDGE)
         2'd1:    edge_hit = fall;
         2'd2:    edge_hit = rise | fall;
         default: edge_hit = rise;
      endcase
   end

   // FORCE_RST swallows any edge or pop on its own cycle
   assign live     = ~reset_i & ~FORCE_RST;
   assign q_empty  = (QUEUED == '0);
   assign q_full   = QUEUED[QUEUE_LOG2];
   assign pop      = live & ~q_empty & (ts == due_q[rd_ptr]);
   assign overlap  = pop & (wcnt > TS_WIDTH'(1));
   assign push_ok  = live & edge_hit & (~q_full | pop);
   assign ovf_drop = live & edge_hit & q_full & ~pop;
   assign due_in   = ts + DELAY + 1'b1;
   assign width_eff = (WIDTH == '0) ? TS_WIDTH'(1) : WIDTH;

   assign n_drop    = {1'b0, ovf_drop} + {1'b0, overlap};
   assign drop_sum  = {1'b0, DROPPED} + {{(TS_WIDTH-1){1'b0}}, n_drop};
   assign drop_next = drop_sum[TS_WIDTH] ? '1 : drop_sum[TS_WIDTH-1:0];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ts        <= '0;
         trig_prev <= 1'b0;
      end else begin
         ts        <= ts + 1'b1;
         trig_prev <= trig_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok)
         due_q[wr_ptr] <= due_in;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || FORCE_RST) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         QUEUED  <= '0;
         wcnt    <= '0;
         out_o   <= 1'b0;
         perr_o  <= 1'b0;
         DROPPED <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   QUEUED <= QUEUED + 1'b1;
            2'b01:   QUEUED <= QUEUED - 1'b1;
            default: QUEUED <= QUEUED;
         endcase

         // a due head on the last high cycle chains straight into the next pulse
         if (pop && !overlap) begin
            wcnt  <= width_eff;
            out_o <= 1'b1;
         end else begin
            if (wcnt != '0) wcnt <= wcnt - 1'b1;
            out_o <= (wcnt > TS_WIDTH'(1));
         end

         if (ovf_drop || overlap) begin
            perr_o  <= 1'b1;
            DROPPED <= drop_next;
         end
      end
   end

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: directed vector table, hand sequences (overflow, mid-pulse reset,
// timestamp wrap on an 8-bit instance) and randomized stimulus against a queue model.
module tb_pulse_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_i, trig_i, FORCE_RST;
   logic [1:0]  TRIG_EDGE;
   logic [31:0] DELAY, WIDTH;
   logic        out_o, perr_o;
   logic [4:0]  QUEUED;
   logic [31:0] DROPPED;

   logic        rst8, trig8;
   logic [7:0]  dly8, wid8;
   logic        out8, perr8;
   logic [4:0]  q8;
   logic [7:0]  drop8;

   pulse_gen #(.QUEUE_LOG2(4), .TS_WIDTH(32)) dut (
      .clk_i(clk), .reset_i(reset_i), .trig_i(trig_i), .TRIG_EDGE(TRIG_EDGE),
      .DELAY(DELAY), .WIDTH(WIDTH), .FORCE_RST(FORCE_RST),
      .out_o(out_o), .perr_o(perr_o), .QUEUED(QUEUED), .DROPPED(DROPPED));

   pulse_gen #(.QUEUE_LOG2(4), .TS_WIDTH(8)) dut8 (
      .clk_i(clk), .reset_i(rst8), .trig_i(trig8), .TRIG_EDGE(2'd0),
      .DELAY(dly8), .WIDTH(wid8), .FORCE_RST(1'b0),
      .out_o(out8), .perr_o(perr8), .QUEUED(q8), .DROPPED(drop8));

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got 0x%0h want 0x%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i   = 1'b1;
      trig_i    = 1'b0;
      FORCE_RST = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [1:0]  sel;
      logic [31:0] dly, wid;
      logic [63:0] trig;   // trig_i level during the cycle where ts == bit index
      logic [63:0] hi;     // expected out_o level per ts
      int          qpk;
      int          drop;
      logic        perr;
   } vec_t;

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic vec_t mk(input string nm, input logic [1:0] s, input int d, input int w,
                               input logic [63:0] tr, input logic [63:0] hi,
                               input int qp, input int dr, input logic pe);
      vec_t v;
      v.name = nm; v.sel = s; v.dly = d; v.wid = w; v.trig = tr; v.hi = hi;
      v.qpk = qp; v.drop = dr; v.perr = pe;
      return v;
   endfunction

   // ---------------- reference model: due-time queue plus absolute pulse end ----------
   logic [31:0] m_ts;
   bit          m_prev;
   logic [31:0] mq[$];
   longint      m_k, m_hi_end, m_drop;
   bit          m_perr;

   task automatic model_edge();
      bit     rise, fall, qual, pop;
      int     sz0, nd;
      if (reset_i) begin
         m_ts = '0; m_prev = 0; mq.delete(); m_k = 0; m_hi_end = 0; m_perr = 0; m_drop = 0;
         return;
      end
      m_k++;
      rise = trig_i && !m_prev;
      fall = !trig_i && m_prev;
      qual = (TRIG_EDGE == 2'd1) ? fall : (TRIG_EDGE == 2'd2) ? (rise || fall) : rise;
      if (FORCE_RST) begin
         mq.delete(); m_hi_end = 0; m_perr = 0; m_drop = 0;
      end else begin
         nd  = 0;
         sz0 = mq.size();
         pop = (sz0 > 0) && (mq[0] == m_ts);
         if (pop) begin
            void'(mq.pop_front());
            if (m_hi_end > m_k) nd++;
            else m_hi_end = m_k + ((WIDTH == 0) ? 1 : longint'(WIDTH));
         end
         if (qual) begin
            if (sz0 == 16 && !pop) nd++;
            else mq.push_back(m_ts + DELAY + 32'd1);
         end
         if (nd > 0) begin
            m_perr = 1;
            m_drop = m_drop + nd;
            if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
         end
      end
      m_prev = trig_i;
      m_ts   = m_ts + 32'd1;
   endtask

   initial begin
      vec_t tbl[7];
      int   mism, qpk, hi_cnt, first_hi;
      logic [38:0] exp_v, got_v;

      reset_i = 1'b1; trig_i = 1'b0; FORCE_RST = 1'b0; TRIG_EDGE = 2'd0;
      DELAY = 0; WIDTH = 0;
      rst8 = 1'b1; trig8 = 1'b0; dly8 = 8'd5; wid8 = 8'd3;

      tbl[0] = mk("basic",     2'd0, 5,  3, rng(10,10), rng(17,19), 1, 0, 1'b0);
      tbl[1] = mk("queued",    2'd0, 20, 2, rng(10,10) | rng(13,13) | rng(16,16),
                  rng(32,33) | rng(35,36) | rng(38,39), 3, 0, 1'b0);
      tbl[2] = mk("overlap",   2'd0, 4,  5, rng(10,10) | rng(12,12), rng(16,20), 2, 1, 1'b1);
      tbl[3] = mk("b2b",       2'd0, 4,  5, rng(10,10) | rng(15,15), rng(16,25), 1, 0, 1'b0);
      tbl[4] = mk("both_w0",   2'd2, 0,  0, rng(10,13), rng(12,12) | rng(16,16), 1, 0, 1'b0);
      tbl[5] = mk("falling",   2'd1, 3,  2, rng(10,13), rng(19,20), 1, 0, 1'b0);
      tbl[6] = mk("sel3_rise", 2'd3, 3,  2, rng(10,13), rng(15,16), 1, 0, 1'b0);

      for (int i = 0; i < 7; i++) begin
         TRIG_EDGE = tbl[i].sel; DELAY = tbl[i].dly; WIDTH = tbl[i].wid;
         do_reset();
         check({tbl[i].name, "_rst"}, {out_o, perr_o, QUEUED, DROPPED}, 0);
         mism = 0; qpk = 0;
         for (int t = 0; t < 64; t++) begin
            trig_i = tbl[i].trig[t];
            if (out_o !== tbl[i].hi[t]) mism++;
            if (int'(QUEUED) > qpk) qpk = int'(QUEUED);
            tick();
         end
         check({tbl[i].name, "_out_mism"}, mism, 0);
         check({tbl[i].name, "_qpeak"}, qpk, tbl[i].qpk);
         check({tbl[i].name, "_dropped"}, DROPPED, tbl[i].drop);
         check({tbl[i].name, "_perr"}, perr_o, tbl[i].perr);
      end

      // overflow: 17 rising edges two cycles apart against a long delay
      TRIG_EDGE = 2'd0; DELAY = 1000; WIDTH = 1;
      do_reset();
      for (int t = 0; t <= 50; t++) begin
         trig_i = (t >= 10 && t <= 42 && (t % 2) == 0);
         tick();
      end
      check("ovf_queued", QUEUED, 16);
      check("ovf_dropped", DROPPED, 1);
      check("ovf_perr", perr_o, 1);
      hi_cnt = 0; first_hi = -1;
      for (int t = 51; t <= 1100; t++) begin
         trig_i = 1'b0;
         if (out_o) begin
            hi_cnt++;
            if (first_hi < 0) first_hi = t;
         end
         tick();
      end
      check("ovf_pulses", hi_cnt, 16);
      check("ovf_first_ts", first_hi, 1012);
      check("ovf_drained", QUEUED, 0);
      FORCE_RST = 1'b1;
      tick();
      FORCE_RST = 1'b0;
      check("force_perr", perr_o, 0);
      check("force_dropped", DROPPED, 0);

      // reset in the middle of a pulse with another entry pending
      DELAY = 10; WIDTH = 10;
      do_reset();
      for (int t = 0; t <= 21; t++) begin
         trig_i = (t == 5 || t == 20);
         tick();
      end
      check("midrst_pre_out", out_o, 1);
      check("midrst_pre_q", QUEUED, 1);
      reset_i = 1'b1; trig_i = 1'b0;
      tick();
      check("midrst_out", out_o, 0);
      check("midrst_q", QUEUED, 0);
      reset_i = 1'b0;
      hi_cnt = 0;
      for (int t = 0; t < 40; t++) begin
         if (out_o) hi_cnt++;
         tick();
      end
      check("midrst_no_pulse", hi_cnt, 0);

      // timestamp wrap on the 8-bit instance: edge at ts=250, due wraps to 0
      rst8 = 1'b1;
      tick();
      tick();
      rst8 = 1'b0;
      mism = 0;
      for (int c = 0; c <= 270; c++) begin
         trig8 = (c == 250);
         if (out8 !== (c >= 257 && c <= 259)) mism++;
         tick();
      end
      check("wrap_out_mism", mism, 0);
      check("wrap_q", q8, 0);
      check("wrap_perr", {perr8, drop8}, 0);

      // randomized run against the model
      TRIG_EDGE = 2'd0; DELAY = 3; WIDTH = 2; trig_i = 1'b0; FORCE_RST = 1'b0;
      reset_i = 1'b1;
      @(posedge clk); model_edge(); #1;
      reset_i = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         reset_i   = ($urandom_range(0, 499) == 0);
         FORCE_RST = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 2) == 0) trig_i = ~trig_i;
         if ($urandom_range(0, 199) == 0) TRIG_EDGE = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0)
            DELAY = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 120) : $urandom_range(0, 20);
         if ($urandom_range(0, 59) == 0) WIDTH = $urandom_range(0, 8);
         @(posedge clk); model_edge(); #1;
         exp_v = {(m_k < m_hi_end), m_perr, 5'(mq.size()), m_drop[31:0]};
         got_v = {out_o, perr_o, QUEUED, DROPPED};
         check($sformatf("rnd_c%0d", c), got_v, exp_v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
